// File: rtl/coin_credit_pkg.sv
// coin_credit_pkg: definitions shared by the coin credit front-end.
// It holds the FSM state encoding, the credit width and ceiling, the coin
// values, and a saturating add helper.
package coin_credit_pkg;

  localparam int CREDIT_W   = 4;
  localparam int CREDIT_MAX = 15;
  localparam int COIN0_VAL  = 1;
  localparam int COIN1_VAL  = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCUM,
    S_VEND,
    S_WAIT_DONE,
    S_REFUND
  } state_e;

  typedef logic [CREDIT_W-1:0] credit_t;

  // Adds a coin value of 0..3 to the credit. The sum is capped at CREDIT_MAX.
  function automatic credit_t sat_add(input credit_t a, input logic [1:0] inc);
    logic [CREDIT_W:0] s;
    s = {1'b0, a} + (CREDIT_W+1)'(inc);
    return (s > (CREDIT_W+1)'(CREDIT_MAX)) ? credit_t'(CREDIT_MAX) : s[CREDIT_W-1:0];
  endfunction

endpackage

// File: rtl/input_debounce.sv
// input_debounce: debounces one raw button and flags each rising edge of the
// debounced level.
//   clk, rst : clock and synchronous active-high reset
//   raw_i    : raw asynchronous button level
//   rise_o   : one-cycle pulse after the debounced level goes 0 -> 1
// The raw input is first captured in a sample flop. The counter then needs
// DEBOUNCE_CYCLES consecutive samples that differ from the current level
// before the level flips. From the first high raw sample, the pulse therefore
// becomes visible DEBOUNCE_CYCLES+1 edges later.
module input_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic rise_o
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             samp_q;
  logic             level_q, level_d;
  logic             prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The counter counts only samples that disagree with the level. Any sample
  // that matches the level restarts the count.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (samp_q != level_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) level_d = samp_q;
      else                                      cnt_d   = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      samp_q  <= 1'b0;
      level_q <= 1'b0;
      prev_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      samp_q  <= raw_i;
      level_q <= level_d;
      prev_q  <= level_q;
      cnt_q   <= cnt_d;
    end
  end

  assign rise_o = level_q & ~prev_q;

endmodule

// File: rtl/coin_credit_tx.sv
// coin_credit_tx: coin acceptor front-end. It debounces the coin, cancel and
// vend buttons, accumulates credit, and runs the vend and refund handshakes
// with the state controller.
//   clk, rst     : clock and synchronous active-high reset
//   coin_in[1:0] : raw coin buttons (bit0 = 1 unit, bit1 = 2 units)
//   cancel_in    : raw refund button
//   vend_in      : raw vend request button
//   vend_done    : one-cycle acknowledge from the controller
//   credito_out  : current credit (registered)
//   avance_out   : one-cycle advance pulse (registered)
//   refund_pulse : one-cycle refund pulse (registered)
//   busy         : high in VEND, WAIT_DONE and REFUND (registered)
module coin_credit_tx
  import coin_credit_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int PRICE           = 5,
  parameter int DONE_TIMEOUT    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          coin_in,
  input  logic                cancel_in,
  input  logic                vend_in,
  input  logic                vend_done,
  output logic [CREDIT_W-1:0] credito_out,
  output logic                avance_out,
  output logic                refund_pulse,
  output logic                busy
);
  localparam int TMR_W = $clog2(DONE_TIMEOUT + 1);

  logic [3:0] raw, ev;
  assign raw = {vend_in, cancel_in, coin_in};

  for (genvar g = 0; g < 4; g++) begin : g_db
    input_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk   (clk),
      .rst   (rst),
      .raw_i (raw[g]),
      .rise_o(ev[g])
    );
  end

  state_e           state_q, state_d;
  credit_t          credit_q, credit_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             avance_q, avance_d;
  logic             refund_q, refund_d;
  logic             busy_q, busy_d;
  logic [1:0]       coin_val;
  logic             enough;

  always_comb begin
    coin_val = (ev[0] ? 2'(COIN0_VAL) : 2'd0) + (ev[1] ? 2'(COIN1_VAL) : 2'd0);
    enough   = int'(credit_q) >= PRICE;
  end

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    tmr_d    = tmr_q;
    unique case (state_q)
      S_IDLE: begin
        credit_d = '0;
        if (coin_val != 2'd0) begin
          credit_d = sat_add('0, coin_val);
          state_d  = S_ACCUM;
        end
      end
      S_ACCUM: begin
        // Cancel outranks vend, and vend outranks coins. A vend with too
        // little credit is ignored, so coins in that cycle still count.
        if (ev[2])                state_d  = S_REFUND;
        else if (ev[3] && enough) state_d  = S_VEND;
        else                      credit_d = sat_add(credit_q, coin_val);
      end
      S_VEND: begin
        state_d = S_WAIT_DONE;
        tmr_d   = '0;
      end
      S_WAIT_DONE: begin
        if (vend_done) begin
          credit_d = credit_q - CREDIT_W'(PRICE);
          state_d  = (credit_d == '0) ? S_IDLE : S_ACCUM;
        end else if (tmr_q == TMR_W'(DONE_TIMEOUT - 1)) begin
          state_d = S_ACCUM;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      S_REFUND: begin
        credit_d = '0;
        state_d  = S_IDLE;
      end
      default: begin
        credit_d = '0;
        state_d  = S_IDLE;
      end
    endcase
    // The flags are decoded from the next state. The registered pulses then
    // line up exactly with the cycle the FSM spends in that state.
    avance_d = (state_d == S_VEND);
    refund_d = (state_d == S_REFUND);
    busy_d   = (state_d == S_VEND) || (state_d == S_WAIT_DONE) || (state_d == S_REFUND);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      credit_q <= '0;
      tmr_q    <= '0;
      avance_q <= 1'b0;
      refund_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      tmr_q    <= tmr_d;
      avance_q <= avance_d;
      refund_q <= refund_d;
      busy_q   <= busy_d;
    end
  end

  assign credito_out  = credit_q;
  assign avance_out   = avance_q;
  assign refund_pulse = refund_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_coin_credit_tx.sv
// tb_coin_credit_tx: directed bench for coin_credit_tx. A behavioural model
// predicts every output on every cycle. Hand-computed literals pin the
// key scenarios.
module tb_coin_credit_tx;
  localparam int D     = 4;
  localparam int PRICE = 5;
  localparam int TMO   = 16;
  localparam int MASK  = (1 << D) - 1;

  localparam int M_IDLE = 0, M_ACC = 1, M_VEND = 2, M_WAIT = 3, M_REF = 4;

  logic       clk, rst;
  logic [1:0] coin_in;
  logic       cancel_in, vend_in, vend_done;
  logic [3:0] credito_out;
  logic       avance_out, refund_pulse, busy;

  coin_credit_tx #(.DEBOUNCE_CYCLES(D), .PRICE(PRICE), .DONE_TIMEOUT(TMO)) dut (
    .clk         (clk),
    .rst         (rst),
    .coin_in     (coin_in),
    .cancel_in   (cancel_in),
    .vend_in     (vend_in),
    .vend_done   (vend_done),
    .credito_out (credito_out),
    .avance_out  (avance_out),
    .refund_pulse(refund_pulse),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model. A button level is accepted once the D most recent
  // samples taken before this edge all agree. A button event is a 0->1 change
  // in that accepted level, seen by the credit logic one edge later.
  logic [15:0] hist [4];
  logic [3:0]  m_lvl, m_plvl, m_ev;
  int          m_mode, m_credit, m_wait, csum;
  logic [3:0]  e_credit;
  logic        e_av, e_rf, e_busy;

  initial begin
    for (int i = 0; i < 4; i++) hist[i] = '0;
    m_lvl = '0; m_plvl = '0; m_mode = M_IDLE; m_credit = 0; m_wait = 0;
    e_credit = '0; e_av = 0; e_rf = 0; e_busy = 0;
  end

  always @(posedge clk) begin
    logic [3:0] rawv;
    logic [15:0] win;
    logic nl;
    rawv = {vend_in, cancel_in, coin_in};
    if (rst) begin
      for (int i = 0; i < 4; i++) hist[i] = '0;
      m_lvl = '0; m_plvl = '0; m_mode = M_IDLE; m_credit = 0; m_wait = 0;
    end else begin
      m_ev = m_lvl & ~m_plvl;
      csum = (m_ev[0] ? 1 : 0) + (m_ev[1] ? 2 : 0);
      case (m_mode)
        M_IDLE: if (csum > 0) begin m_credit = csum; m_mode = M_ACC; end
        M_ACC: begin
          if (m_ev[2]) m_mode = M_REF;
          else if (m_ev[3] && m_credit >= PRICE) m_mode = M_VEND;
          else m_credit = (m_credit + csum > 15) ? 15 : m_credit + csum;
        end
        M_VEND: begin m_mode = M_WAIT; m_wait = 0; end
        M_WAIT: begin
          if (vend_done) begin
            m_credit = m_credit - PRICE;
            m_mode = (m_credit == 0) ? M_IDLE : M_ACC;
          end else begin
            m_wait++;
            if (m_wait == TMO) m_mode = M_ACC;
          end
        end
        default: begin m_credit = 0; m_mode = M_IDLE; end
      endcase
      for (int i = 0; i < 4; i++) begin
        win = hist[i] & 16'(MASK);
        nl = m_lvl[i];
        if (win == 16'(MASK)) nl = 1'b1;
        else if (win == 16'd0) nl = 1'b0;
        m_plvl[i] = m_lvl[i];
        m_lvl[i]  = nl;
        hist[i]   = {hist[i][14:0], rawv[i]};
      end
    end
    e_credit = 4'(m_credit);
    e_av     = (m_mode == M_VEND);
    e_rf     = (m_mode == M_REF);
    e_busy   = (m_mode == M_VEND) || (m_mode == M_WAIT) || (m_mode == M_REF);
  end

  int n_cmp = 0, n_err = 0, n_av = 0, n_rf = 0;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Advance one cycle and compare every output with the model.
  task automatic tick();
    @(negedge clk);
    chk("model credito_out", 8'(credito_out), 8'(e_credit));
    chk("model avance_out", 8'(avance_out), 8'(e_av));
    chk("model refund_pulse", 8'(refund_pulse), 8'(e_rf));
    chk("model busy", 8'(busy), 8'(e_busy));
    if (avance_out === 1'b1) n_av++;
    if (refund_pulse === 1'b1) n_rf++;
  endtask

  task automatic press(input logic [1:0] c, input logic cn, input logic vd);
    coin_in = c; cancel_in = cn; vend_in = vd;
    repeat (6) tick();
    coin_in = 2'b00; cancel_in = 1'b0; vend_in = 1'b0;
    repeat (8) tick();
  endtask

  task automatic done_pulse();
    vend_done = 1'b1; tick();
    vend_done = 1'b0; repeat (3) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int av0, rf0;
    rst = 1'b1; coin_in = 2'b00; cancel_in = 1'b0; vend_in = 1'b0; vend_done = 1'b0;
    repeat (3) tick();
    chk("reset credit", 8'(credito_out), 8'd0);
    chk("reset avance", 8'(avance_out), 8'd0);
    chk("reset refund", 8'(refund_pulse), 8'd0);
    chk("reset busy", 8'(busy), 8'd0);
    rst = 1'b0;
    repeat (2) tick();

    // coin0 held 6 cycles: the credit must be 0 after edge 5 and 1 after edge 6
    coin_in = 2'b01;
    repeat (5) tick();
    chk("coin edge5 credit", 8'(credito_out), 8'd0);
    tick();
    chk("coin edge6 credit", 8'(credito_out), 8'd1);
    coin_in = 2'b00;
    repeat (8) tick();

    rf0 = n_rf;
    press(2'b00, 1'b1, 1'b0);
    chk("cancel refund count", 8'(n_rf - rf0), 8'd1);
    chk("cancel credit", 8'(credito_out), 8'd0);

    // two-cycle glitch
    coin_in = 2'b01; repeat (2) tick();
    coin_in = 2'b00; repeat (10) tick();
    chk("glitch credit", 8'(credito_out), 8'd0);

    // 2+2+1, then vend and done
    press(2'b10, 0, 0); press(2'b10, 0, 0); press(2'b01, 0, 0);
    chk("2+2+1 credit", 8'(credito_out), 8'd5);
    av0 = n_av;
    press(2'b00, 0, 1);
    chk("vend busy", 8'(busy), 8'd1);
    chk("vend avance count", 8'(n_av - av0), 8'd1);
    done_pulse();
    chk("done credit 0", 8'(credito_out), 8'd0);
    chk("done busy idle", 8'(busy), 8'd0);

    // credit 7, vend -> 2; credit 4, vend ignored
    press(2'b10, 0, 0); press(2'b10, 0, 0); press(2'b10, 0, 0); press(2'b01, 0, 0);
    chk("credit 7", 8'(credito_out), 8'd7);
    press(2'b00, 0, 1);
    done_pulse();
    chk("after vend credit 2", 8'(credito_out), 8'd2);
    chk("after vend busy", 8'(busy), 8'd0);
    press(2'b10, 0, 0);
    chk("credit 4", 8'(credito_out), 8'd4);
    av0 = n_av;
    press(2'b00, 0, 1);
    chk("low credit no avance", 8'(n_av - av0), 8'd0);
    chk("low credit kept", 8'(credito_out), 8'd4);

    // saturation, and vend_done ignored outside WAIT_DONE
    repeat (5) press(2'b10, 0, 0);
    chk("credit 14", 8'(credito_out), 8'd14);
    done_pulse();
    chk("stray done ignored", 8'(credito_out), 8'd14);
    press(2'b11, 0, 0);
    chk("14+3 saturates", 8'(credito_out), 8'd15);
    press(2'b01, 0, 0);
    chk("stays 15", 8'(credito_out), 8'd15);

    // cancel wins over vend in the same cycle
    press(2'b00, 1, 0);
    press(2'b10, 0, 0); press(2'b10, 0, 0); press(2'b10, 0, 0);
    chk("credit 6", 8'(credito_out), 8'd6);
    av0 = n_av; rf0 = n_rf;
    press(2'b00, 1, 1);
    chk("cancel+vend refund", 8'(n_rf - rf0), 8'd1);
    chk("cancel+vend no avance", 8'(n_av - av0), 8'd0);
    chk("cancel+vend credit", 8'(credito_out), 8'd0);

    // timeout in WAIT_DONE, then reset mid-wait
    press(2'b10, 0, 0); press(2'b10, 0, 0); press(2'b01, 0, 0);
    av0 = n_av;
    press(2'b00, 0, 1);
    repeat (12) tick();
    chk("timeout avance count", 8'(n_av - av0), 8'd1);
    chk("timeout credit", 8'(credito_out), 8'd5);
    chk("timeout busy", 8'(busy), 8'd0);
    press(2'b00, 0, 1);
    chk("rewait busy", 8'(busy), 8'd1);
    rst = 1'b1;
    tick();
    chk("rst credit", 8'(credito_out), 8'd0);
    chk("rst avance", 8'(avance_out), 8'd0);
    chk("rst refund", 8'(refund_pulse), 8'd0);
    chk("rst busy", 8'(busy), 8'd0);
    tick();
    rst = 1'b0;
    av0 = n_av; rf0 = n_rf;
    repeat (20) tick();
    chk("post-rst no avance", 8'(n_av - av0), 8'd0);
    chk("post-rst no refund", 8'(n_rf - rf0), 8'd0);
    chk("post-rst credit", 8'(credito_out), 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/coin_credit_tx.md
COIN_CREDIT_TX -- requirements
Module: coin_credit_tx

Interface
Parameters:
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4, meaning consecutive identical samples needed to accept a raw input level.
REQ-002 SHALL have parameter PRICE, default 5, meaning credit units consumed per vend.
REQ-003 SHALL have parameter DONE_TIMEOUT, default 16, meaning the maximum cycles to wait for vend_done.
Ports:
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port coin_in, input, 2 bits: raw coin buttons; bit0 is worth 1 unit, bit1 is worth 2 units.
REQ-007 SHALL have port cancel_in, input, 1 bit: raw refund button.
REQ-008 SHALL have port vend_in, input, 1 bit: raw vend-request button.
REQ-009 SHALL have port vend_done, input, 1 bit: one-cycle acknowledge from the state controller.
REQ-010 SHALL have port credito_out, output, 4 bits: current credit, feeding the controller's credit bus.
REQ-011 SHALL have port avance_out, output, 1 bit: one-cycle advance pulse to the controller.
REQ-012 SHALL have port refund_pulse, output, 1 bit: one-cycle pulse when credit is returned.
REQ-013 SHALL have port busy, output, 1 bit: high in states VEND, WAIT_DONE and REFUND.

Function
REQ-014 SHALL debounce each raw input (coin_in[0], coin_in[1], cancel_in, vend_in) independently. The debounced level changes only after DEBOUNCE_CYCLES consecutive equal samples; any differing sample restarts the count.
REQ-015 SHALL generate a one-cycle event on each rising edge of a debounced level. Falling edges produce no event.
REQ-016 SHALL update credit exactly DEBOUNCE_CYCLES+2 rising edges after a raw coin is first sampled high, provided the coin stays stable.
REQ-017 SHALL implement FSM states IDLE, ACCUM, VEND, WAIT_DONE and REFUND.
REQ-018 In IDLE, SHALL hold credit at 0. A coin event adds its value and moves the FSM to ACCUM.
REQ-019 In ACCUM, coin events SHALL add 1, 2, or 3 (both coins in the same cycle), with the sum saturating at 15.
REQ-020 In ACCUM, priority SHALL be cancel > vend > coin. Coin events in the same cycle as an accepted cancel or vend are discarded.
REQ-021 In ACCUM, a cancel event SHALL move the FSM to REFUND.
REQ-022 In ACCUM, a vend event with credit >= PRICE SHALL move the FSM to VEND. A vend event with credit < PRICE is ignored, and the state and credit are unchanged.
REQ-023 In VEND, SHALL assert avance_out for exactly one cycle, then move to WAIT_DONE.
REQ-024 In WAIT_DONE, coin, vend and cancel events SHALL be ignored and lost.
REQ-025 In WAIT_DONE, vend_done SHALL set credit to credit-PRICE. The FSM moves to IDLE if the result is 0, otherwise to ACCUM.
REQ-026 In WAIT_DONE, if vend_done is absent for DONE_TIMEOUT cycles, SHALL return to ACCUM with credit unchanged.
REQ-027 vend_done SHALL be ignored in every state except WAIT_DONE.
REQ-028 In REFUND, SHALL assert refund_pulse for one cycle, clear credit to 0, and move to IDLE.
REQ-029 credito_out, avance_out, refund_pulse and busy SHALL all be registered outputs.

Reset
REQ-030 While rst is high at a rising edge, SHALL force state IDLE, credit 0, all debounced levels 0, and debounce and timeout counters 0.
REQ-031 While rst is high, SHALL drive credito_out=0, avance_out=0, refund_pulse=0 and busy=0.
REQ-032 A reset asserted mid-vend or mid-refund SHALL abort the operation with no pulse emitted afterwards.
REQ-033 After reset deasserts, a raw input already held high SHALL be treated as a new rising edge once it is debounced.

Structure
REQ-034 A shared package coin_credit_pkg SHALL hold the FSM state encoding, the credit width (4), the credit maximum (15), and the coin values.
REQ-035 The block SHALL use one sub-module, input_debounce (debounce plus rising-edge pulse), instantiated four times.

Verification
REQ-036 The bench SHALL cover: coin_in[0] held 6 cycles -> credito_out becomes 1 at edge DEBOUNCE_CYCLES+2 (6); a 2-cycle glitch leaves credit 0.
REQ-037 The bench SHALL cover: coins 2+2+1 then vend -> one avance_out pulse and busy=1; vend_done -> credito_out=0 and the FSM is in IDLE.
REQ-038 The bench SHALL cover: credit 7 then vend -> after vend_done, credit is 2 and the FSM is in ACCUM; vend with credit 4 -> no avance_out pulse.
REQ-039 The bench SHALL cover: credit 14 plus a double coin (+3) -> credit 15, and a further coin leaves it at 15.
REQ-040 The bench SHALL cover: credit 6 then cancel and vend in the same cycle -> refund_pulse asserted, no avance_out, credit 0.
REQ-041 The bench SHALL cover: vend with no vend_done -> after 16 cycles the FSM is in ACCUM with credit intact; rst asserted in WAIT_DONE -> all outputs 0 on the next edge.
